// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package demux_pkg;

    // Width of the accepted-word counter.
    localparam int XFER_CNT_WIDTH = 16;

    // Lowest bit of channel k inside a flat bus of w-bit channel words.
    function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One demux output channel: a single valid/data register with load and drain
// control. An empty slot always holds zero data.
module demux_slot #(
    parameter int DAT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,   // upstream word is written into this slot
    input  logic                 ready_i,  // downstream accept for this slot
    input  logic [DAT_WIDTH-1:0] data_i,
    output logic                 valid_o,
    output logic [DAT_WIDTH-1:0] data_o
);

    logic                 valid_q, valid_d;
    logic [DAT_WIDTH-1:0] data_q,  data_d;
    logic                 drain;

    // ready_i only matters while the slot holds a word.
    assign drain = valid_q && ready_i;

    // Next state: a load wins over a drain, so a same-cycle drain+load keeps
    // the slot full with the new word; a drain alone empties and zeroes it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    // Slot state register; reset drops any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each upstream word to one of 2**SEL_WIDTH
// single-register output channels, with per-channel valid/ready handshakes
// and a count of accepted words.
module stream_demux
    import demux_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int SEL_WIDTH = 4,
    localparam int N        = 2 ** SEL_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DAT_WIDTH-1:0]      in_data,
    input  logic [SEL_WIDTH-1:0]      sel_in,
    output logic [N-1:0]              out_valid,
    input  logic [N-1:0]              out_ready,
    output logic [N*DAT_WIDTH-1:0]    demux_out,
    output logic [XFER_CNT_WIDTH-1:0] xfer_cnt
);

    logic                      accept;
    logic [N-1:0]              load_vec;
    logic [XFER_CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

    // Only the addressed channel can stall upstream, and only when it is
    // full and not being drained this cycle. Independent of in_valid.
    assign in_ready = !out_valid[sel_in] || out_ready[sel_in];
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign load_vec[gi] = accept && (sel_in == SEL_WIDTH'(gi));

            demux_slot #(
                .DAT_WIDTH (DAT_WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (load_vec[gi]),
                .ready_i (out_ready[gi]),
                .data_i  (in_data),
                .valid_o (out_valid[gi]),
                .data_o  (demux_out[slice_lsb(gi, DAT_WIDTH) +: DAT_WIDTH])
            );
        end
    endgenerate

    // Accepted-word counter advances once per accept and wraps naturally.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (accept) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed + randomized bench for stream_demux (DAT_WIDTH=8, SEL_WIDTH=2)
// with a per-channel queue scoreboard.
module tb_stream_demux;

    localparam int DW = 8;
    localparam int SW = 2;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] sel_in;
    logic [NC-1:0] out_valid;
    logic [NC-1:0] out_ready;
    logic [NC*DW-1:0] demux_out;
    logic [15:0]   xfer_cnt;

    stream_demux #(.DAT_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel_in    (sel_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .demux_out (demux_out),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] cnt_m  = '0;
    logic [7:0]  sb_q [NC][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                         input logic [NC-1:0] r);
        in_valid  = v;
        sel_in    = s;
        in_data   = d;
        out_ready = r;
    endtask

    // Called at a falling edge with inputs set: checks outputs against the
    // scoreboard, updates it for this cycle's handshakes, advances one cycle.
    task automatic cycle();
        logic exp_rdy;
        #1;
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(sb_q[k].size() != 0));
            chk($sformatf("chan_data[%0d]", k), 32'(demux_out[k*DW +: DW]),
                (sb_q[k].size() != 0) ? 32'(sb_q[k][0]) : 32'h0);
        end
        chk("xfer_cnt", 32'(xfer_cnt), 32'(cnt_m));
        exp_rdy = (sb_q[sel_in].size() == 0) || out_ready[sel_in];
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        for (int k = 0; k < NC; k++) begin
            if (sb_q[k].size() != 0 && out_ready[k]) void'(sb_q[k].pop_front());
        end
        if (in_valid && exp_rdy) begin
            sb_q[sel_in].push_back(in_data);
            cnt_m = cnt_m + 16'd1;
            $display("accept ch=%0d data=%02h cnt=%0d", sel_in, in_data, cnt_m);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int unsigned n_bulk;
        logic [15:0] cnt_before;

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();                               // reset state

        // Single word to channel 2
        drive(1, 2, 8'hA5, 4'b0000);
        cycle();
        drive(0, 0, 0, 4'b0000);
        #1;
        chk("single_valid", 32'(out_valid), 32'h4);
        chk("single_data",  demux_out, 32'h00A5_0000);
        chk("single_cnt",   32'(xfer_cnt), 32'h1);
        cycle();
        drive(0, 0, 0, 4'b0100);
        cycle();
        drive(0, 0, 0, 4'b0000);
        cycle();

        // Backpressure on channel 1, other channel still accepts
        drive(1, 1, 8'h11, 4'b0000);
        cycle();
        drive(1, 1, 8'h22, 4'b0000);
        #1 chk("bp_stall", 32'(in_ready), 32'h0);
        cycle();
        drive(1, 3, 8'h33, 4'b0000);
        #1 chk("bp_other", 32'(in_ready), 32'h1);
        cycle();

        // Fill all four then drain in parallel
        drive(1, 0, 8'h44, 4'b0000);
        cycle();
        drive(1, 2, 8'h55, 4'b0000);
        cycle();
        drive(0, 0, 0, 4'b1111);
        #1 chk("all_full", 32'(out_valid), 32'hF);
        cycle();
        drive(0, 0, 0, 4'b0000);
        #1;
        chk("pdrain_valid", 32'(out_valid), 32'h0);
        chk("pdrain_data",  demux_out, 32'h0);
        cycle();

        // Full-throughput stream into channel 0
        cnt_before = cnt_m;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, DW'(i), 4'b0001);
            #1 chk("tput_ready", 32'(in_ready), 32'h1);
            cycle();
        end
        drive(0, 0, 0, 4'b0001);
        #1 chk("tput_last", 32'(demux_out[DW-1:0]), 32'h08);
        chk("tput_cnt", 32'(xfer_cnt - cnt_before), 32'd8);
        cycle();
        drive(0, 0, 0, 4'b0000);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), SW'($urandom_range(0, NC-1)),
                  DW'($urandom), NC'($urandom));
            cycle();
        end

        // Counter wrap: empty everything, then stream until 0xFFFF accepts
        drive(0, 0, 0, 4'b1111);
        cycle();
        drive(0, 0, 0, 4'b1111);
        cycle();
        n_bulk = 32'(16'hFFFF - cnt_m);
        drive(1, 0, 8'h5A, 4'b0001);
        repeat (n_bulk) @(posedge clk);
        @(negedge clk);
        cnt_m = cnt_m + 16'(n_bulk);
        if (n_bulk != 0) begin
            sb_q[0].delete();
            sb_q[0].push_back(8'h5A);
        end
        drive(0, 0, 0, 4'b0000);
        #1 chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
        cycle();
        drive(1, 1, 8'h66, 4'b0000);
        cycle();
        drive(0, 0, 0, 4'b0000);
        #1 chk("cnt_wrap", 32'(xfer_cnt), 32'h0);
        cycle();

        // Reset mid-operation with channels 0, 1 and 3 full
        drive(1, 3, 8'h77, 4'b0000);
        cycle();
        drive(1, 2, 8'h99, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  demux_out, 32'h0);
        chk("rst_cnt",   32'(xfer_cnt), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_noacc_valid", 32'(out_valid), 32'h0);
        chk("rst_noacc_cnt",   32'(xfer_cnt), 32'h0);
        for (int k = 0; k < NC; k++) sb_q[k].delete();
        cnt_m = '0;
        rst_n = 1'b1;
        drive(0, 0, 0, 4'b0000);
        cycle();
        drive(1, 2, 8'h99, 4'b0000);
        cycle();
        drive(0, 0, 0, 4'b0000);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
